// File: rtl/daq_pkg.sv
// Shared definitions for the DAQ ADC front end: FSM encoding, default sizes,
// oversampling select codes and the ADC reset pulse length.
package daq_pkg;

  localparam int unsigned NUM_CH_DEF  = 8;
  localparam int unsigned DATA_W_DEF  = 16;
  localparam int unsigned CH_W        = 3;
  localparam int unsigned OS_W        = 3;
  localparam int unsigned ADC_RST_LEN = 5;

  // AD7606 OS[2:0] codes
  localparam logic [OS_W-1:0] OS_NONE = 3'd0;
  localparam logic [OS_W-1:0] OS_X2   = 3'd1;
  localparam logic [OS_W-1:0] OS_X4   = 3'd2;
  localparam logic [OS_W-1:0] OS_X8   = 3'd3;
  localparam logic [OS_W-1:0] OS_X16  = 3'd4;
  localparam logic [OS_W-1:0] OS_X32  = 3'd5;
  localparam logic [OS_W-1:0] OS_X64  = 3'd6;

  typedef enum logic [2:0] {
    S_ADC_RST,
    S_IDLE,
    S_CONVST,
    S_BUSY_HI,
    S_BUSY_LO,
    S_RD,
    S_PRESENT
  } adc_state_e;

endpackage

// File: rtl/daq_conv_timer.sv
// Conversion period timer: free-running period counter, tick strobe and
// saturating count of ticks that arrive while the reader is busy.
// Ports: clk, rst_n (sync, active low), en, in_idle -> tick_c, overrun_cnt.
module daq_conv_timer #(
  parameter int unsigned CONV_PERIOD = 2000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       in_idle,
  output logic       tick_c,
  output logic [7:0] overrun_cnt
);

  localparam int unsigned CNT_W = $clog2(CONV_PERIOD + 1);

  logic [CNT_W-1:0] cnt;

  assign tick_c = en && (cnt == CNT_W'(CONV_PERIOD - 1));

  // Period counter, parked at zero while disabled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // A tick outside IDLE is a skipped conversion
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun_cnt <= '0;
    end else if (tick_c && !in_idle && (overrun_cnt != 8'hFF)) begin
      overrun_cnt <= overrun_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/daq_adc_reader.sv
// AD7606-style parallel ADC reader: periodic CONVST, BUSY handshake with
// timeout, sequential CS/RD channel reads, valid/ready sample stream.
// Ports: clk_i, reset_n_i (sync, active low), en_i, os_sel_i -> adc_os_o;
//   ADC pins adc_reset_o, adc_convst_n_o, adc_cs_n_o, adc_rd_n_o, adc_busy_i,
//   adc_db_i; stream sample_o/_ch_o/_first_o/_last_o/_valid_o, sample_ready_i;
//   status overrun_cnt_o, tmo_err_o.
// Build option: ADC_TEST_PATTERN_EN replaces captured data with
//   {frame_cnt, ch} for link bring-up.
module daq_adc_reader
  import daq_pkg::*;
#(
  parameter int unsigned NUM_CH      = NUM_CH_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned CONV_PERIOD = 2000,
  parameter int unsigned CONVST_LOW  = 4,
  parameter int unsigned RD_LOW      = 4,
  parameter int unsigned BUSY_TMO    = 1024
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              en_i,
  input  logic [OS_W-1:0]   os_sel_i,
  output logic [OS_W-1:0]   adc_os_o,
  output logic              adc_reset_o,
  output logic              adc_convst_n_o,
  output logic              adc_cs_n_o,
  output logic              adc_rd_n_o,
  input  logic              adc_busy_i,
  input  logic [DATA_W-1:0] adc_db_i,
  output logic [DATA_W-1:0] sample_o,
  output logic [CH_W-1:0]   sample_ch_o,
  output logic              sample_first_o,
  output logic              sample_last_o,
  output logic              sample_valid_o,
  input  logic              sample_ready_i,
  output logic [7:0]        overrun_cnt_o,
  output logic              tmo_err_o
);

  localparam int unsigned TMR_W = $clog2(BUSY_TMO + CONVST_LOW + RD_LOW + ADC_RST_LEN + 1);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  adc_state_e        state, state_nxt;
  logic [TMR_W-1:0]  tmr, tmr_nxt;
  logic [CH_W-1:0]   ch, ch_nxt;
  logic              tick_c;
  logic              capture_c;
  logic              tmo_c;
  logic              latch_os_c;
  logic              frame_done_c;
  logic [DATA_W-1:0] cap_data_c;

  daq_conv_timer #(
    .CONV_PERIOD (CONV_PERIOD)
  ) u_timer (
    .clk         (clk_i),
    .rst_n       (reset_n_i),
    .en          (en_i),
    .in_idle     (state == S_IDLE),
    .tick_c      (tick_c),
    .overrun_cnt (overrun_cnt_o)
  );

`ifdef ADC_TEST_PATTERN_EN
  logic [12:0] frame_cnt;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      frame_cnt <= '0;
    end else if (frame_done_c) begin
      frame_cnt <= frame_cnt + 13'd1;
    end
  end

  assign cap_data_c = {frame_cnt[DATA_W-4:0], ch};
`else
  assign cap_data_c = adc_db_i;
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state <= S_ADC_RST;
      tmr   <= '0;
      ch    <= '0;
    end else begin
      state <= state_nxt;
      tmr   <= tmr_nxt;
      ch    <= ch_nxt;
    end
  end

  // Next state; tmr counts cycles spent in the current state
  always_comb begin
    state_nxt    = state;
    tmr_nxt      = tmr + TMR_W'(1);
    ch_nxt       = ch;
    capture_c    = 1'b0;
    tmo_c        = 1'b0;
    latch_os_c   = 1'b0;
    frame_done_c = 1'b0;
    case (state)
      S_ADC_RST: begin
        if (tmr == TMR_W'(ADC_RST_LEN - 1)) begin
          state_nxt = S_IDLE;
          tmr_nxt   = '0;
        end
      end
      S_IDLE: begin
        tmr_nxt = '0;
        if (tick_c) begin
          latch_os_c = 1'b1;
          state_nxt  = S_CONVST;
        end
      end
      S_CONVST: begin
        if (tmr == TMR_W'(CONVST_LOW - 1)) begin
          state_nxt = S_BUSY_HI;
          tmr_nxt   = '0;
        end
      end
      S_BUSY_HI: begin
        if (adc_busy_i) begin
          state_nxt = S_BUSY_LO;
          tmr_nxt   = '0;
        end else if (tmr == TMR_W'(BUSY_TMO - 1)) begin
          tmo_c     = 1'b1;
          state_nxt = S_IDLE;
          tmr_nxt   = '0;
        end
      end
      S_BUSY_LO: begin
        if (!adc_busy_i) begin
          state_nxt = S_RD;
          tmr_nxt   = '0;
          ch_nxt    = '0;
        end else if (tmr == TMR_W'(BUSY_TMO - 1)) begin
          tmo_c     = 1'b1;
          state_nxt = S_IDLE;
          tmr_nxt   = '0;
        end
      end
      S_RD: begin
        // Data bus is sampled at the end of the last RD_N-low cycle
        if (tmr == TMR_W'(RD_LOW - 1)) begin
          capture_c = 1'b1;
          state_nxt = S_PRESENT;
          tmr_nxt   = '0;
        end
      end
      S_PRESENT: begin
        tmr_nxt = '0;
        if (sample_ready_i) begin
          if (ch == LAST_CH) begin
            frame_done_c = 1'b1;
            state_nxt    = S_IDLE;
          end else begin
            ch_nxt    = ch + CH_W'(1);
            state_nxt = S_RD;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
        tmr_nxt   = '0;
      end
    endcase
  end

  // ADC pins and stream flags registered from the next state
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      adc_reset_o    <= 1'b1;
      adc_convst_n_o <= 1'b1;
      adc_cs_n_o     <= 1'b1;
      adc_rd_n_o     <= 1'b1;
      adc_os_o       <= OS_NONE;
      sample_valid_o <= 1'b0;
      tmo_err_o      <= 1'b0;
    end else begin
      adc_reset_o    <= (state_nxt == S_ADC_RST);
      adc_convst_n_o <= (state_nxt != S_CONVST);
      adc_cs_n_o     <= (state_nxt != S_RD);
      adc_rd_n_o     <= (state_nxt != S_RD);
      sample_valid_o <= (state_nxt == S_PRESENT);
      tmo_err_o      <= tmo_err_o | tmo_c;
      if (latch_os_c) begin
        adc_os_o <= os_sel_i;
      end
    end
  end

  // Sample payload, held while the consumer stalls
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      sample_o       <= '0;
      sample_ch_o    <= '0;
      sample_first_o <= 1'b0;
      sample_last_o  <= 1'b0;
    end else if (capture_c) begin
      sample_o       <= cap_data_c;
      sample_ch_o    <= ch;
      sample_first_o <= (ch == '0);
      sample_last_o  <= (ch == LAST_CH);
    end
  end

endmodule

// File: tb/tb_daq_adc_reader.sv
// Directed bench for daq_adc_reader with a simple AD7606 BUSY/data model.
module tb_daq_adc_reader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0;
  logic [2:0]  os_sel = 3'd3;
  logic        adc_busy = 1'b0;
  logic [15:0] adc_db = 16'h0;
  logic        ready = 1'b1;

  logic [2:0]  adc_os;
  logic        adc_reset, adc_convst_n, adc_cs_n, adc_rd_n;
  logic [15:0] sample;
  logic [2:0]  sample_ch;
  logic        sample_first, sample_last, sample_valid;
  logic [7:0]  overrun_cnt;
  logic        tmo_err;

  int n_cmp = 0;
  int n_err = 0;
  int rd_falls = 0;
  int conv_falls = 0;
  bit busy_en = 1'b1;
  int frm = 0;

  always #5 clk = ~clk;

  daq_adc_reader #(
    .NUM_CH(8), .DATA_W(16), .CONV_PERIOD(2000),
    .CONVST_LOW(4), .RD_LOW(4), .BUSY_TMO(1024)
  ) dut (
    .clk_i          (clk),
    .reset_n_i      (reset_n),
    .en_i           (en),
    .os_sel_i       (os_sel),
    .adc_os_o       (adc_os),
    .adc_reset_o    (adc_reset),
    .adc_convst_n_o (adc_convst_n),
    .adc_cs_n_o     (adc_cs_n),
    .adc_rd_n_o     (adc_rd_n),
    .adc_busy_i     (adc_busy),
    .adc_db_i       (adc_db),
    .sample_o       (sample),
    .sample_ch_o    (sample_ch),
    .sample_first_o (sample_first),
    .sample_last_o  (sample_last),
    .sample_valid_o (sample_valid),
    .sample_ready_i (ready),
    .overrun_cnt_o  (overrun_cnt),
    .tmo_err_o      (tmo_err)
  );

  // ADC data: 0x1000 + channel, channel = read index within the frame
  always @(negedge adc_rd_n) begin
    adc_db = 16'h1000 + 16'(rd_falls % 8);
    rd_falls++;
  end

  // BUSY: rises 2 cycles after CONVST falls, high for 40 cycles
  always @(negedge adc_convst_n) begin
    conv_falls++;
    if (busy_en) begin
      repeat (2) @(posedge clk);
      #1 adc_busy = 1'b1;
      repeat (40) @(posedge clk);
      #1 adc_busy = 1'b0;
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_data(input int f, input int c);
`ifdef ADC_TEST_PATTERN_EN
    return {13'(f), 3'(c)};
`else
    return 16'h1000 + 16'(c);
`endif
  endfunction

  // Wait for the next sample, check it, and accept it if ready is high
  task automatic take(input int c);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!sample_valid && k < 3000);
    chk_eq($sformatf("valid f%0d ch%0d", frm, c), 32'(sample_valid), 32'd1);
    if (!sample_valid) return;
    chk_eq($sformatf("data f%0d ch%0d", frm, c), 32'(sample), 32'(exp_data(frm, c)));
    chk_eq($sformatf("ch f%0d ch%0d", frm, c), 32'(sample_ch), 32'(c));
    chk_eq($sformatf("first f%0d ch%0d", frm, c), 32'(sample_first), 32'(c == 0));
    chk_eq($sformatf("last f%0d ch%0d", frm, c), 32'(sample_last), 32'(c == 7));
    if (ready) begin
      @(posedge clk);
      #1;
      if (c == 7) frm++;
    end
  endtask

  task automatic wait_convst(output bit found);
    int k;
    k = 0;
    found = 1'b0;
    while (!found && k < 2500) begin
      @(negedge clk);
      k++;
      if (!adc_convst_n) found = 1'b1;
    end
  endtask

  initial begin
    int k, conv_k, rst_hi, w, r0, bad, vcnt, c0;
    bit found;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_eq("rst adc_reset", 32'(adc_reset), 32'd1);
    chk_eq("rst convst_n", 32'(adc_convst_n), 32'd1);
    chk_eq("rst cs_n", 32'(adc_cs_n), 32'd1);
    chk_eq("rst rd_n", 32'(adc_rd_n), 32'd1);
    chk_eq("rst os", 32'(adc_os), 32'd0);
    chk_eq("rst valid", 32'(sample_valid), 32'd0);
    chk_eq("rst sample", 32'(sample), 32'd0);
    chk_eq("rst ch", 32'(sample_ch), 32'd0);
    chk_eq("rst first", 32'(sample_first), 32'd0);
    chk_eq("rst last", 32'(sample_last), 32'd0);
    chk_eq("rst overrun", 32'(overrun_cnt), 32'd0);
    chk_eq("rst tmo", 32'(tmo_err), 32'd0);
    en = 1'b1;
    @(posedge clk);
    #1 reset_n = 1'b1;

    // ADC reset pulse length and first CONVST position
    k = -1;
    conv_k = -1;
    rst_hi = 0;
    while (conv_k < 0 && k < 3000) begin
      @(negedge clk);
      k++;
      if (adc_reset) rst_hi++;
      if (!adc_convst_n) conv_k = k;
    end
    chk_eq("adc_reset width", 32'(rst_hi), 32'd5);
    chk_eq("first convst cycle", 32'(conv_k), 32'd2000);
    chk_eq("os latched f0", 32'(adc_os), 32'd3);
    w = 0;
    while (!adc_convst_n && w < 50) begin
      w++;
      @(negedge clk);
    end
    chk_eq("convst width", 32'(w), 32'd4);
    for (int c = 0; c < 8; c++) take(c);

    // Frame 1: stall at ch3, os_sel change mid-frame
    for (int c = 0; c < 3; c++) take(c);
    ready = 1'b0;
    take(3);
    r0 = rd_falls;
    bad = 0;
    os_sel = 3'd5;
    repeat (100) begin
      @(negedge clk);
      if (!sample_valid || sample !== exp_data(frm, 3) || sample_ch !== 3'd3) bad++;
    end
    chk_eq("stall stable", 32'(bad), 32'd0);
    chk_eq("stall no rd", 32'(rd_falls - r0), 32'd0);
    ready = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 4; c < 8; c++) take(c);
    chk_eq("os held mid-frame", 32'(adc_os), 32'd3);

    // Frame 2: new os_sel applied at this conversion
    wait_convst(found);
    chk_eq("convst f2", 32'(found), 32'd1);
    chk_eq("os latched f2", 32'(adc_os), 32'd5);
    for (int c = 0; c < 8; c++) take(c);

    // Frame 3: long stall at ch0 spans one tick
    ready = 1'b0;
    take(0);
    repeat (2500) @(negedge clk);
    chk_eq("overrun cnt", 32'(overrun_cnt), 32'd1);
    chk_eq("overrun valid held", 32'(sample_valid), 32'd1);
    ready = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 1; c < 8; c++) take(c);

    // Frame 4: BUSY never rises
    busy_en = 1'b0;
    wait_convst(found);
    chk_eq("convst f4", 32'(found), 32'd1);
    k = 0;
    vcnt = 0;
    while (!tmo_err && k < 1200) begin
      @(negedge clk);
      k++;
      if (sample_valid) vcnt++;
    end
    chk_eq("tmo latency", 32'(k), 32'd1028);
    chk_eq("tmo flag", 32'(tmo_err), 32'd1);
    chk_eq("tmo no samples", 32'(vcnt), 32'd0);
    busy_en = 1'b1;

    // Frame 5: next tick restarts normally
    wait_convst(found);
    chk_eq("convst after tmo", 32'(found), 32'd1);
    for (int c = 0; c < 8; c++) take(c);
    chk_eq("overrun final", 32'(overrun_cnt), 32'd1);
    chk_eq("tmo sticky", 32'(tmo_err), 32'd1);

    // Disabled: no further conversions
    en = 1'b0;
    c0 = conv_falls;
    repeat (2100) @(negedge clk);
    chk_eq("disabled no convst", 32'(conv_falls - c0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
